// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - state type shared by serial-block controllers
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, DATA_BITS LSB first, one stop bit
module uart_tx #(
  parameter int DATA_BITS      = 8,
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 tx
);

  localparam int BIT_W = $clog2(DATA_BITS + 2);
  localparam int CLK_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic                 busy_q, busy_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS:0]   shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CLK_W-1:0]     clk_cnt_q, clk_cnt_d;

  // shift_q holds the remaining data bits plus the stop bit; the start bit goes straight to tx on load
  always_comb begin
    busy_d    = busy_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    if (!busy_q) begin
      if (send) begin
        busy_d    = 1'b1;
        tx_d      = 1'b0;
        shift_d   = {1'b1, data};
        bit_cnt_d = '0;
        clk_cnt_d = '0;
      end
    end else if (clk_cnt_q == CLK_W'(CLOCKS_PER_BIT - 1)) begin
      clk_cnt_d = '0;
      if (bit_cnt_q == BIT_W'(DATA_BITS + 1)) begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
      end else begin
        tx_d      = shift_q[0];
        shift_d   = {1'b1, shift_q[DATA_BITS:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
    end
  end

  assign busy = busy_q;
  assign tx   = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter among NUM_REQ requesters
module uart_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           grant_valid,
  output logic                           busy,
  output logic                           tx
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int IW1 = IDW + 1;

  arb_state_t           state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;

  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic [IDW-1:0]       win_next;
  logic [DATA_BITS-1:0] win_data;
  logic [IW1-1:0]       cand;
  logic                 tx_send;
  logic                 tx_busy;

  // Search from ptr_q upward, wrapping modulo NUM_REQ; first asserted request wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + IW1'(k);
      if (cand >= IW1'(NUM_REQ)) begin
        cand = cand - IW1'(NUM_REQ);
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_data = data[i*DATA_BITS +: DATA_BITS];
      end
    end
    win_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    tx_send    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d = win_idx;
          hold_d     = win_data;
          ptr_d      = win_next;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_send = !rst;
        state_d = WAIT;
      end
      WAIT: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst so an abort in the SEND cycle never reports the byte as accepted
  always_comb begin
    ack = '0;
    if (state_q == SEND && !rst) begin
      ack[grant_id_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
    end
  end

  uart_tx #(
    .DATA_BITS      (DATA_BITS),
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .send (tx_send),
    .data (hold_q),
    .busy (tx_busy),
    .tx   (tx)
  );

  assign grant_id    = grant_id_q;
  assign grant_valid = (state_q == SEND) || (state_q == WAIT);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic        busy;
  logic        tx;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_BITS      (8),
    .CLOCKS_PER_BIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .busy        (busy),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where ack is first seen (the SEND cycle)
  task automatic wait_ack(output logic [3:0] a, output logic [1:0] g);
    int n;
    n = 0;
    while (ack == 4'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_timeout", {31'b0, n < 200}, 32'd1);
    a = ack;
    g = grant_id;
  endtask

  // Called at the negedge of the start-bit's first cycle; checks all 40 tx samples
  task automatic frame_check(input logic [7:0] b, output int acks);
    logic [9:0] f;
    f    = {1'b1, b, 1'b0};
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      check("tx_bit", {31'b0, tx}, {31'b0, f[i/4]});
      if (ack != 4'b0) acks++;
      @(negedge clk);
    end
  endtask

  logic [3:0] a;
  logic [1:0] g;
  int         n;
  int         m;
  logic [3:0] exp_ack [5];
  logic [1:0] exp_gid [5];

  initial begin
    rst  = 1'b1;
    req  = 4'b0;
    data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ack", {28'b0, ack}, 32'h0);
    check("rst_grant_valid", {31'b0, grant_valid}, 32'h0);
    check("rst_grant_id", {30'b0, grant_id}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_tx", {31'b0, tx}, 32'h1);
    rst = 1'b0;

    // Single frame of 0xA5 from requester 0
    req        = 4'b0001;
    data[7:0]  = 8'hA5;
    @(negedge clk);
    check("a5_ack", {28'b0, ack}, 32'h1);
    check("a5_grant_valid", {31'b0, grant_valid}, 32'h1);
    check("a5_grant_id", {30'b0, grant_id}, 32'h0);
    check("a5_busy", {31'b0, busy}, 32'h1);
    check("a5_tx_before_start", {31'b0, tx}, 32'h1);
    req = 4'b0;
    @(negedge clk);
    frame_check(8'hA5, n);
    check("a5_extra_acks", n, 32'd0);
    check("a5_wait_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    check("a5_idle_busy", {31'b0, busy}, 32'h0);
    check("a5_idle_grant_valid", {31'b0, grant_valid}, 32'h0);

    // Round robin with all four requesting, then pointer wrap with 1001
    rst = 1'b1;
    req = 4'b1111;
    data = 32'h44332211;
    @(negedge clk);
    rst = 1'b0;
    exp_ack[0] = 4'b0001; exp_gid[0] = 2'd0;
    exp_ack[1] = 4'b0010; exp_gid[1] = 2'd1;
    exp_ack[2] = 4'b0100; exp_gid[2] = 2'd2;
    exp_ack[3] = 4'b1000; exp_gid[3] = 2'd3;
    exp_ack[4] = 4'b0001; exp_gid[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, g);
      check("rr_ack", {28'b0, a}, {28'b0, exp_ack[k]});
      check("rr_gid", {30'b0, g}, {30'b0, exp_gid[k]});
      if (k == 3) req = 4'b1001;
      @(negedge clk);
    end
    wait_ack(a, g);
    check("wrap_ack_3", {28'b0, a}, 32'h8);
    check("wrap_gid_3", {30'b0, g}, 32'h3);

    // Continuous requester 0: 40 busy cycles, then send exactly 2 cycles after busy falls
    rst = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(a, g);
    @(negedge clk);
    n = 0;
    while (dut.tx_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_busy_len", n, 32'd40);
    m = 0;
    while (ack == 4'b0 && m < 10) begin
      m++;
      @(negedge clk);
    end
    check("b2b_gap", m, 32'd2);
    check("b2b_ack", {28'b0, ack}, 32'h1);
    @(negedge clk);
    check("b2b_start_bit", {31'b0, tx}, 32'h0);

    // Reset mid data bit of a requester 2 frame
    rst = 1'b1;
    req = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    data[23:16] = 8'h3C;
    req = 4'b0100;
    wait_ack(a, g);
    check("r2_ack", {28'b0, a}, 32'h4);
    check("r2_gid", {30'b0, g}, 32'h2);
    repeat (11) @(negedge clk);
    check("r2_mid_bit1", {31'b0, tx}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("r2_rst_tx", {31'b0, tx}, 32'h1);
    check("r2_rst_busy", {31'b0, busy}, 32'h0);
    check("r2_rst_ack", {28'b0, ack}, 32'h0);
    check("r2_rst_grant_valid", {31'b0, grant_valid}, 32'h0);
    rst = 1'b0;
    wait_ack(a, g);
    check("r2_regrant_ack", {28'b0, a}, 32'h4);
    check("r2_regrant_gid", {30'b0, g}, 32'h2);

    // Reset landing in the SEND cycle suppresses the ack and the frame
    rst = 1'b1;
    #1;
    check("send_rst_ack", {28'b0, ack}, 32'h0);
    @(negedge clk);
    check("send_rst_tx", {31'b0, tx}, 32'h1);
    check("send_rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    req = 4'b0;
    @(negedge clk);

    // Requester 1 drops req right after capture; frame still completes
    data[15:8] = 8'h5A;
    req = 4'b0010;
    wait_ack(a, g);
    check("r1_ack", {28'b0, a}, 32'h2);
    req = 4'b0;
    @(negedge clk);
    frame_check(8'h5A, n);
    check("r1_extra_acks", n, 32'd0);
    @(negedge clk);
    check("r1_idle", {31'b0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
